// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, fixed
// WIDTH-cycle latency, valid/ready handshakes on both operand and product sides.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]     b_sh_q, b_sh_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   acc_sum;

  // Partial-product step: add the shifted multiplicand when the current multiplier bit is set.
  assign acc_sum = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case leaves one unassigned (no latches).
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    count_d     = count_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = {{WIDTH{1'b0}}, a};
          b_sh_d  = b;
          acc_d   = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_sum;
        a_sh_d  = a_sh_q << 1;
        b_sh_d  = b_sh_q >> 1;
        count_d = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          state_d     = DONE;
          product_d   = acc_sum;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
